// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared types and constants for the RSA job sequencer
package rsa_pkg;

    localparam int DEFAULT_WIDTH = 128;

    localparam logic MODE_ENCRYPT = 1'b0;
    localparam logic MODE_DECRYPT = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INV_PULSE = 3'd1,
        INV_WAIT  = 3'd2,
        EXP_PULSE = 3'd3,
        EXP_WAIT  = 3'd4,
        DONE      = 3'd5
    } seq_state_e;

endpackage

// File: rtl/rsa_wait_timer.sv
// rtl/rsa_wait_timer.sv - clear/enable wait counter flagging the cycle that reaches TIMEOUT
module rsa_wait_timer #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic hit_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Asserted in the wait cycle whose increment brings the count to TIMEOUT.
    assign hit_o = en_i && (count_q == LAST_CNT);

endmodule

// File: rtl/rsa_job_sequencer.sv
// rtl/rsa_job_sequencer.sv - accepts RSA jobs and drives the control core pulse protocol
module rsa_job_sequencer
    import rsa_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = 65535,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_p,
    input  logic [WIDTH-1:0]     in_q,
    input  logic                 in_mode,
    input  logic [2*WIDTH-1:0]   in_msg,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_msg,
    output logic                 out_error,
    output logic [WIDTH-1:0]     p,
    output logic [WIDTH-1:0]     q,
    output logic                 encrypt_decrypt,
    output logic [2*WIDTH-1:0]   msg_in,
    output logic                 reset_inverter,
    output logic                 reset_mod_exp,
    input  logic                 inverter_finish,
    input  logic                 mod_exp_finish,
    input  logic [2*WIDTH-1:0]   msg_out
);

    seq_state_e state_q, state_d;

    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0] out_msg_q, out_msg_d;
    logic               out_error_q, out_error_d;
    logic [WIDTH-1:0]   p_q, p_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               mode_q, mode_d;
    logic [2*WIDTH-1:0] msg_in_q, msg_in_d;
    logic               rst_inv_q, rst_inv_d;
    logic               rst_exp_q, rst_exp_d;

    logic timer_clear;
    logic timer_en;
    logic timer_hit;

    rsa_wait_timer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear_i (timer_clear),
        .en_i    (timer_en),
        .hit_o   (timer_hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_msg_q   <= '0;
            out_error_q <= 1'b0;
            p_q         <= '0;
            q_q         <= '0;
            mode_q      <= MODE_ENCRYPT;
            msg_in_q    <= '0;
            rst_inv_q   <= 1'b0;
            rst_exp_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_msg_q   <= out_msg_d;
            out_error_q <= out_error_d;
            p_q         <= p_d;
            q_q         <= q_d;
            mode_q      <= mode_d;
            msg_in_q    <= msg_in_d;
            rst_inv_q   <= rst_inv_d;
            rst_exp_q   <= rst_exp_d;
        end
    end

    // Finish is checked ahead of the timer, so a finish on the hit cycle wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d = INV_PULSE;
                end
            end
            INV_PULSE: state_d = INV_WAIT;
            INV_WAIT: begin
                if (inverter_finish) begin
                    state_d = EXP_PULSE;
                end else if (timer_hit) begin
                    state_d = DONE;
                end
            end
            EXP_PULSE: state_d = EXP_WAIT;
            EXP_WAIT: begin
                if (mod_exp_finish || timer_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake and pulse outputs are registered from the next state so they
    // line up with the state they describe.
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        rst_inv_d   = (state_d == INV_PULSE);
        rst_exp_d   = (state_d == EXP_PULSE);
        out_msg_d   = out_msg_q;
        out_error_d = out_error_q;
        p_d         = p_q;
        q_d         = q_q;
        mode_d      = mode_q;
        msg_in_d    = msg_in_q;

        timer_clear = (state_q == INV_PULSE) || (state_q == EXP_PULSE);
        timer_en    = ((state_q == INV_WAIT) && !inverter_finish) ||
                      ((state_q == EXP_WAIT) && !mod_exp_finish);

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    p_d      = in_p;
                    q_d      = in_q;
                    mode_d   = in_mode;
                    msg_in_d = in_msg;
                end
            end
            INV_WAIT: begin
                if (!inverter_finish && timer_hit) begin
                    out_error_d = 1'b1;
                    out_msg_d   = '0;
                end
            end
            EXP_WAIT: begin
                if (mod_exp_finish) begin
                    out_error_d = 1'b0;
                    out_msg_d   = msg_out;
                end else if (timer_hit) begin
                    out_error_d = 1'b1;
                    out_msg_d   = '0;
                end
            end
            default: ;
        endcase
    end

    assign in_ready        = in_ready_q;
    assign out_valid       = out_valid_q;
    assign out_msg         = out_msg_q;
    assign out_error       = out_error_q;
    assign p               = p_q;
    assign q               = q_q;
    assign encrypt_decrypt = mode_q;
    assign msg_in          = msg_in_q;
    assign reset_inverter  = rst_inv_q;
    assign reset_mod_exp   = rst_exp_q;

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// tb/tb_rsa_job_sequencer.sv - scoreboard bench for rsa_job_sequencer with a toy control model
module tb_rsa_job_sequencer;

    localparam int W  = 128;
    localparam int MW = 2 * W;

    typedef struct {
        logic [MW-1:0] msg;
        logic          err;
        int            inv_n;
        int            exp_n;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst [2];
    logic          in_valid [2];
    logic          in_ready [2];
    logic          in_mode [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic          out_error [2];
    logic          encrypt_decrypt [2];
    logic          reset_inverter [2];
    logic          reset_mod_exp [2];
    logic          inverter_finish [2];
    logic          mod_exp_finish [2];
    logic [W-1:0]  in_p [2];
    logic [W-1:0]  in_q [2];
    logic [W-1:0]  p [2];
    logic [W-1:0]  q [2];
    logic [MW-1:0] in_msg [2];
    logic [MW-1:0] out_msg [2];
    logic [MW-1:0] msg_in [2];
    logic [MW-1:0] msg_out [2];

    int   inv_delay [2];
    int   exp_delay [2];
    int   inv_cnt [2];
    int   exp_cnt [2];
    int   inv_n [2];
    int   exp_n [2];
    logic inv_run [2];
    logic exp_run [2];

    exp_t sb0 [$];
    exp_t sb1 [$];

    int errors = 0;
    int checks = 0;

    rsa_job_sequencer #(.WIDTH(W), .TIMEOUT(65535), .CNT_W(16)) dut (
        .clk(clk), .reset(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_p(in_p[0]), .in_q(in_q[0]), .in_mode(in_mode[0]), .in_msg(in_msg[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_msg(out_msg[0]),
        .out_error(out_error[0]), .p(p[0]), .q(q[0]), .encrypt_decrypt(encrypt_decrypt[0]),
        .msg_in(msg_in[0]), .reset_inverter(reset_inverter[0]), .reset_mod_exp(reset_mod_exp[0]),
        .inverter_finish(inverter_finish[0]), .mod_exp_finish(mod_exp_finish[0]), .msg_out(msg_out[0])
    );

    rsa_job_sequencer #(.WIDTH(W), .TIMEOUT(16), .CNT_W(5)) dut_to (
        .clk(clk), .reset(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_p(in_p[1]), .in_q(in_q[1]), .in_mode(in_mode[1]), .in_msg(in_msg[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_msg(out_msg[1]),
        .out_error(out_error[1]), .p(p[1]), .q(q[1]), .encrypt_decrypt(encrypt_decrypt[1]),
        .msg_in(msg_in[1]), .reset_inverter(reset_inverter[1]), .reset_mod_exp(reset_mod_exp[1]),
        .inverter_finish(inverter_finish[1]), .mod_exp_finish(mod_exp_finish[1]), .msg_out(msg_out[1])
    );

    // Toy control core: finish rises N cycles after its start pulse; encrypt adds {p,q}, decrypt subtracts it.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                inv_run[i] <= 1'b0;
                exp_run[i] <= 1'b0;
                inverter_finish[i] <= 1'b0;
                mod_exp_finish[i] <= 1'b0;
                msg_out[i] <= '0;
                inv_n[i] <= 0;
                exp_n[i] <= 0;
            end else begin
                if (in_valid[i] && in_ready[i]) begin
                    inv_n[i] <= 0;
                    exp_n[i] <= 0;
                end
                if (reset_inverter[i]) begin
                    inv_n[i] <= inv_n[i] + 1;
                    inverter_finish[i] <= 1'b0;
                    inv_run[i] <= (inv_delay[i] != 0);
                    inv_cnt[i] <= inv_delay[i];
                end else if (inv_run[i]) begin
                    if (inv_cnt[i] == 1) begin
                        inverter_finish[i] <= 1'b1;
                        inv_run[i] <= 1'b0;
                    end else begin
                        inv_cnt[i] <= inv_cnt[i] - 1;
                    end
                end
                if (reset_mod_exp[i]) begin
                    exp_n[i] <= exp_n[i] + 1;
                    mod_exp_finish[i] <= 1'b0;
                    exp_run[i] <= (exp_delay[i] != 0);
                    exp_cnt[i] <= exp_delay[i];
                end else if (exp_run[i]) begin
                    if (exp_cnt[i] == 1) begin
                        mod_exp_finish[i] <= 1'b1;
                        exp_run[i] <= 1'b0;
                        msg_out[i] <= encrypt_decrypt[i] ? msg_in[i] - {p[i], q[i]}
                                                         : msg_in[i] + {p[i], q[i]};
                    end else begin
                        exp_cnt[i] <= exp_cnt[i] - 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [MW-1:0] m, input logic e, input int ni, input int ne);
        exp_t r;
        r.msg = m;
        r.err = e;
        r.inv_n = ni;
        r.exp_n = ne;
        return r;
    endfunction

    // Monitor: pops one expectation per accepted result.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (out_valid[i] && out_ready[i]) begin
                exp_t e;
                if ((i == 0 && sb0.size() == 0) || (i == 1 && sb1.size() == 0)) begin
                    chk("unexpected_result", MW'(1), MW'(0));
                end else begin
                    e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
                    chk($sformatf("out_msg[%0d]", i), out_msg[i], e.msg);
                    chk($sformatf("out_error[%0d]", i), MW'(out_error[i]), MW'(e.err));
                    chk($sformatf("inv_pulses[%0d]", i), MW'(inv_n[i]), MW'(e.inv_n));
                    chk($sformatf("exp_pulses[%0d]", i), MW'(exp_n[i]), MW'(e.exp_n));
                end
            end
        end
    end

    task automatic check_reset(input int i);
        chk("rst_in_ready", MW'(in_ready[i]), MW'(1));
        chk("rst_out_valid", MW'(out_valid[i]), MW'(0));
        chk("rst_out_error", MW'(out_error[i]), MW'(0));
        chk("rst_out_msg", out_msg[i], MW'(0));
        chk("rst_p", MW'(p[i]), MW'(0));
        chk("rst_q", MW'(q[i]), MW'(0));
        chk("rst_msg_in", msg_in[i], MW'(0));
        chk("rst_mode", MW'(encrypt_decrypt[i]), MW'(0));
        chk("rst_reset_inverter", MW'(reset_inverter[i]), MW'(0));
        chk("rst_reset_mod_exp", MW'(reset_mod_exp[i]), MW'(0));
    endtask

    task automatic send(input int i, input logic [W-1:0] pp, input logic [W-1:0] qq,
                        input logic md, input logic [MW-1:0] m, input exp_t e);
        int n;
        n = 0;
        if (i == 0) sb0.push_back(e);
        else sb1.push_back(e);
        in_p[i] = pp;
        in_q[i] = qq;
        in_mode[i] = md;
        in_msg[i] = m;
        in_valid[i] = 1'b1;
        while (!in_ready[i] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_ready", MW'(in_ready[i]), MW'(1));
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
    endtask

    task automatic wait_result(input int i, output logic [MW-1:0] m, output int lat);
        lat = 0;
        while (!out_valid[i] && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("result_arrives", MW'(out_valid[i]), MW'(1));
        m = out_msg[i];
    endtask

    initial begin
        logic [W-1:0]  p1, q1, p2, q2;
        logic [MW-1:0] m1, m2, r, m;
        int            lat, n;

        p1 = 128'd113680897410347;
        q1 = 128'd7999808077935876437321;
        m1 = 256'h00000000000000f03a00000000000000;
        p2 = 128'd8475698667747010771;
        q2 = 128'd11297384090418420749;
        m2 = 256'he2596d9d;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1;
            in_valid[i] = 1'b0;
            in_mode[i] = 1'b0;
            in_p[i] = '0;
            in_q[i] = '0;
            in_msg[i] = '0;
            out_ready[i] = 1'b1;
            inv_delay[i] = 1;
            exp_delay[i] = 1;
        end
        repeat (4) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        check_reset(0);
        check_reset(1);

        // Encrypt job with finishes after 7 and 20 cycles.
        inv_delay[0] = 7;
        exp_delay[0] = 20;
        send(0, p1, q1, 1'b0, m1, mk(m1 + {p1, q1}, 1'b0, 1, 1));
        wait_result(0, r, lat);

        // Chain: encrypt, then decrypt the returned message.
        inv_delay[0] = 3;
        exp_delay[0] = 5;
        send(0, p2, q2, 1'b0, m2, mk(m2 + {p2, q2}, 1'b0, 1, 1));
        wait_result(0, r, lat);
        send(0, p2, q2, 1'b1, r, mk(256'he2596d9d, 1'b0, 1, 1));
        wait_result(0, r, lat);

        // Hold the result with back-pressure while another job is offered.
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        inv_delay[0] = 2;
        exp_delay[0] = 2;
        m = 256'h1234_5678_9abc_def0;
        send(0, p1, q2, 1'b0, m, mk(m + {p1, q2}, 1'b0, 1, 1));
        wait_result(0, r, lat);
        in_p[0] = p2;
        in_msg[0] = 256'hdead;
        in_valid[0] = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            chk("hold_out_valid", MW'(out_valid[0]), MW'(1));
            chk("hold_out_msg", out_msg[0], m + {p1, q2});
            chk("hold_in_ready", MW'(in_ready[0]), MW'(0));
            chk("hold_no_new_pulse", MW'(reset_inverter[0]), MW'(0));
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;

        // Reset while waiting on mod_exp, then a normal job.
        inv_delay[0] = 2;
        exp_delay[0] = 30;
        send(0, p2, q1, 1'b0, m2, mk(MW'(0), 1'b0, 1, 1));
        n = 0;
        while (!reset_mod_exp[0] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("exp_pulse_seen", MW'(reset_mod_exp[0]), MW'(1));
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        if (sb0.size() > 0) r = sb0.pop_back().msg;
        check_reset(0);
        inv_delay[0] = 5;
        exp_delay[0] = 5;
        send(0, p2, q1, 1'b1, m2, mk(m2 - {p2, q1}, 1'b0, 1, 1));
        wait_result(0, r, lat);

        // TIMEOUT=16 instance: inverter never finishes.
        inv_delay[1] = 0;
        send(1, p1, q1, 1'b0, m1, mk(MW'(0), 1'b1, 1, 0));
        wait_result(1, r, lat);
        chk("inv_timeout_latency", MW'(lat), MW'(17));

        // Finish on the same cycle the counter reaches TIMEOUT: success.
        inv_delay[1] = 3;
        exp_delay[1] = 15;
        send(1, p2, q2, 1'b1, m1, mk(m1 - {p2, q2}, 1'b0, 1, 1));
        wait_result(1, r, lat);

        // One cycle later than that: exp timeout.
        inv_delay[1] = 3;
        exp_delay[1] = 16;
        send(1, p2, q2, 1'b0, m1, mk(MW'(0), 1'b1, 1, 1));
        wait_result(1, r, lat);

        n = 0;
        while ((sb0.size() + sb1.size()) != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("scoreboard_drained", MW'(sb0.size() + sb1.size()), MW'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
